// File: rtl/i2c_cmd_seq.sv
// Command sequencer in front of i2c_master: queues host register commands,
// launches them one at a time and queues one response per command.
module i2c_cmd_seq #(
   parameter int DEPTH    = 4,
   parameter int AW       = 2,
   parameter int START_TO = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [6:0]    cmd_addr,
   input  logic          cmd_rw,
   input  logic [4:0]    cmd_mem_addr,
   input  logic [7:0]    cmd_data,
   output logic [AW:0]   cmd_count,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_rw,
   output logic [7:0]    rsp_data,
   output logic          rsp_err,
   output logic          m_en,
   output logic [6:0]    m_addr,
   output logic          m_rw,
   output logic [4:0]    m_mem_addr,
   output logic [7:0]    m_data_wr,
   input  logic [7:0]    m_data_rd,
   input  logic          m_ack_err,
   input  logic          m_busy
);

   localparam int TW = $clog2(START_TO);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TO_LAST = TW'(START_TO - 1);

   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP
   } state_t;

   state_t state, state_nx;

   logic [20:0]   cmd_mem [DEPTH];
   logic [AW-1:0] cwr, crd;
   logic [AW:0]   ccnt;

   logic [9:0]    rsp_mem [DEPTH];
   logic [AW-1:0] rwr, rrd;
   logic [AW:0]   rcnt;
   logic [9:0]    rsp_head;

   logic [TW-1:0] tcnt;
   logic [7:0]    res_data;
   logic          res_err;

   logic cmd_push, rsp_pop, rsp_full;
   logic launch, done, tmo, rsp_push;

   assign cmd_ready = (ccnt != FULL);
   assign cmd_push  = cmd_valid && cmd_ready;
   assign cmd_count = ccnt;
   assign rsp_full  = (rcnt == FULL);
   assign rsp_valid = (rcnt != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign rsp_head  = rsp_mem[rrd];
   // Stale RAM contents are masked while the response queue is empty
   assign rsp_rw    = rsp_valid & rsp_head[9];
   assign rsp_data  = rsp_valid ? rsp_head[8:1] : 8'h00;
   assign rsp_err   = rsp_valid & rsp_head[0];

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      done     = 1'b0;
      tmo      = 1'b0;
      rsp_push = 1'b0;
      unique case (state)
         IDLE: begin
            if (ccnt != '0 && !rsp_full) begin
               launch   = 1'b1;
               state_nx = LAUNCH;
            end
         end
         LAUNCH: state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (m_busy) begin
               state_nx = WAIT_DONE;
            end else if (tcnt == TO_LAST) begin
               tmo      = 1'b1;
               state_nx = RESP;
            end
         end
         WAIT_DONE: begin
            if (!m_busy) begin
               done     = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            rsp_push = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cwr] <= {cmd_addr, cmd_rw, cmd_mem_addr, cmd_data};
      if (rsp_push) rsp_mem[rwr] <= {m_rw, res_data, res_err};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cwr        <= '0;
         crd        <= '0;
         ccnt       <= '0;
         rwr        <= '0;
         rrd        <= '0;
         rcnt       <= '0;
         tcnt       <= '0;
         res_data   <= 8'h00;
         res_err    <= 1'b0;
         m_en       <= 1'b0;
         m_addr     <= '0;
         m_rw       <= 1'b0;
         m_mem_addr <= '0;
         m_data_wr  <= '0;
      end else begin
         state <= state_nx;
         m_en  <= (state_nx == LAUNCH);
         if (cmd_push) cwr <= cwr + AW'(1);
         if (launch) begin
            {m_addr, m_rw, m_mem_addr, m_data_wr} <= cmd_mem[crd];
            crd <= crd + AW'(1);
         end
         ccnt <= ccnt + (AW+1)'(cmd_push) - (AW+1)'(launch);
         if (state == LAUNCH) tcnt <= '0;
         else if (state == WAIT_BUSY && !m_busy) tcnt <= tcnt + TW'(1);
         if (done) begin
            res_err  <= m_ack_err;
            res_data <= m_rw ? 8'h00 : m_data_rd;
         end else if (tmo) begin
            res_err  <= 1'b1;
            res_data <= 8'h00;
         end
         if (rsp_push) rwr <= rwr + AW'(1);
         if (rsp_pop) rrd <= rrd + AW'(1);
         rcnt <= rcnt + (AW+1)'(rsp_push) - (AW+1)'(rsp_pop);
      end
   end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Bench for i2c_cmd_seq: behavioural i2c_master model plus per-scenario
// tasks checking launches and responses against bench-computed expectations.
module tb_i2c_cmd_seq;

   localparam int DEPTH = 4;
   localparam int AW = 2;
   localparam int START_TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0;
   logic cmd_ready;
   logic [6:0] cmd_addr = '0;
   logic cmd_rw = 1'b0;
   logic [4:0] cmd_mem_addr = '0;
   logic [7:0] cmd_data = '0;
   logic [AW:0] cmd_count;
   logic rsp_valid;
   logic rsp_ready = 1'b0;
   logic rsp_rw;
   logic [7:0] rsp_data;
   logic rsp_err;
   logic m_en;
   logic [6:0] m_addr;
   logic m_rw;
   logic [4:0] m_mem_addr;
   logic [7:0] m_data_wr;
   logic [7:0] m_data_rd;
   logic m_ack_err;
   logic m_busy;

   i2c_cmd_seq #(.DEPTH(DEPTH), .AW(AW), .START_TO(START_TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
      .cmd_mem_addr(cmd_mem_addr), .cmd_data(cmd_data),
      .cmd_count(cmd_count),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw),
      .m_mem_addr(m_mem_addr), .m_data_wr(m_data_wr),
      .m_data_rd(m_data_rd), .m_ack_err(m_ack_err), .m_busy(m_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // mode 0: normal, 1: never busy, 2: busy held while hold_busy
   typedef struct {
      int mode;
      int dly;
      int len;
      logic [7:0] rd;
      logic err;
   } beh_t;

   beh_t beh_q[$];
   bit hold_busy = 1'b0;
   logic [20:0] en_log[$];
   int en_cyc[$];
   int dbl_en = 0;
   int ovl = 0;
   logic en_prev = 1'b0;

   function automatic beh_t mk_beh(int mode, int dly, int len,
                                   logic [7:0] rd, logic err);
      beh_t b;
      b.mode = mode; b.dly = dly; b.len = len; b.rd = rd; b.err = err;
      return b;
   endfunction

   function automatic logic [9:0] exp_rsp(logic rw, beh_t b);
      if (b.mode == 1) return {rw, 8'h00, 1'b1};
      return {rw, rw ? 8'h00 : b.rd, b.err};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_en === 1'b1) begin
         en_log.push_back({m_addr, m_rw, m_mem_addr, m_data_wr});
         en_cyc.push_back(cyc);
         if (en_prev === 1'b1) dbl_en++;
         if (m_busy === 1'b1) ovl++;
      end
      en_prev = m_en;
   end

   initial begin
      beh_t b;
      m_busy = 1'b0;
      m_data_rd = 8'h00;
      m_ack_err = 1'b0;
      forever begin
         @(negedge clk);
         if (m_en === 1'b1) begin
            if (beh_q.size() > 0) b = beh_q.pop_front();
            else b = mk_beh(0, 2, 3, 8'h00, 1'b0);
            if (b.mode != 1) begin
               repeat (b.dly) @(negedge clk);
               m_busy = 1'b1;
               m_data_rd = 8'($urandom);
               m_ack_err = 1'($urandom);
               if (b.mode == 2) begin
                  while (hold_busy) @(negedge clk);
               end else begin
                  repeat (b.len) @(negedge clk);
               end
               m_busy = 1'b0;
               m_data_rd = b.rd;
               m_ack_err = b.err;
            end
         end
      end
   end

   task automatic push_cmd(input logic [20:0] c, output bit ok);
      ok = 1'b0;
      {cmd_addr, cmd_rw, cmd_mem_addr, cmd_data} = c;
      cmd_valid = 1'b1;
      for (int t = 0; t < 300; t++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input int bound, output bit ok, output logic [9:0] r);
      ok = 1'b0;
      r = '0;
      rsp_ready = 1'b1;
      for (int t = 0; t < bound; t++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            r = {rsp_rw, rsp_data, rsp_err};
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b1;
      {cmd_addr, cmd_rw, cmd_mem_addr, cmd_data} = {7'h55, 1'b1, 5'h1f, 8'hff};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmd_valid = 1'b0;
      checks++;
      if (m_en !== 1'b0) begin
         errors++; $display("FAIL reset_m_en got %0h want 0", m_en);
      end
      checks++;
      if ({m_addr, m_rw, m_mem_addr, m_data_wr} !== 21'h0) begin
         errors++;
         $display("FAIL reset_m_fields got %0h want 0",
                  {m_addr, m_rw, m_mem_addr, m_data_wr});
      end
      checks++;
      if (cmd_count !== 3'd0) begin
         errors++; $display("FAIL reset_cmd_count got %0d want 0", cmd_count);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready got %0h want 1", cmd_ready);
      end
      checks++;
      if ({rsp_valid, rsp_rw, rsp_data, rsp_err} !== 11'h0) begin
         errors++;
         $display("FAIL reset_rsp got %0h want 0",
                  {rsp_valid, rsp_rw, rsp_data, rsp_err});
      end
      repeat (4) @(negedge clk);
      checks++;
      if (en_log.size() != 0 || cmd_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_ignore_cmd got launches=%0d count=%0d want 0/0",
                  en_log.size(), cmd_count);
      end
   endtask

   task automatic test_write();
      bit ok;
      logic [9:0] r;
      int c0;
      en_log.delete(); en_cyc.delete(); dbl_en = 0;
      beh_q.push_back(mk_beh(0, 2, 20, 8'h5A, 1'b0));
      c0 = cyc;
      push_cmd({7'd1, 1'b1, 5'd3, 8'h33}, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wr_push got 0 want 1"); end
      get_rsp(200, ok, r);
      checks++;
      if (!ok || r !== {1'b1, 8'h00, 1'b0}) begin
         errors++; $display("FAIL wr_rsp got ok=%0d %0h want 200", ok, r);
      end
      checks++;
      if (en_log.size() != 1) begin
         errors++; $display("FAIL wr_launches got %0d want 1", en_log.size());
      end else begin
         checks++;
         if (en_log[0] !== {7'd1, 1'b1, 5'd3, 8'h33}) begin
            errors++; $display("FAIL wr_fields got %0h want %0h",
                               en_log[0], {7'd1, 1'b1, 5'd3, 8'h33});
         end
         checks++;
         if (en_cyc[0] - c0 != 2) begin
            errors++; $display("FAIL wr_latency got %0d want 2", en_cyc[0] - c0);
         end
      end
      checks++;
      if (m_data_wr !== 8'h33 || m_addr !== 7'd1 || dbl_en != 0) begin
         errors++; $display("FAIL wr_hold got %0h/%0h dbl=%0d want 33/1/0",
                            m_data_wr, m_addr, dbl_en);
      end
   endtask

   task automatic test_read();
      bit ok;
      logic [9:0] r;
      en_log.delete(); en_cyc.delete();
      beh_q.push_back(mk_beh(0, 2, 4, 8'hBB, 1'b0));
      beh_q.push_back(mk_beh(0, 3, 2, 8'hBB, 1'b1));
      push_cmd({7'd2, 1'b0, 5'd1, 8'($urandom)}, ok);
      push_cmd({7'd2, 1'b0, 5'd1, 8'($urandom)}, ok);
      get_rsp(200, ok, r);
      checks++;
      if (!ok || r !== {1'b0, 8'hBB, 1'b0}) begin
         errors++; $display("FAIL rd_ok got ok=%0d %0h want 176", ok, r);
      end
      get_rsp(200, ok, r);
      checks++;
      if (!ok || r !== {1'b0, 8'hBB, 1'b1}) begin
         errors++; $display("FAIL rd_ackerr got ok=%0d %0h want 177", ok, r);
      end
      checks++;
      if (en_log.size() != 2 || en_log[0][20:8] !== {7'd2, 1'b0, 5'd1}) begin
         errors++; $display("FAIL rd_launch got n=%0d want 2", en_log.size());
      end
   endtask

   task automatic test_fill();
      bit ok;
      logic [9:0] r;
      logic [20:0] c[5];
      beh_t b[5];
      en_log.delete(); en_cyc.delete();
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         c[i] = {7'h15, 1'($urandom), 5'(i), 8'($urandom)};
         b[i] = (i == 0) ? mk_beh(2, 2, 0, 8'($urandom), 1'b0)
                         : mk_beh(0, 1, 2, 8'($urandom), 1'($urandom));
         beh_q.push_back(b[i]);
      end
      for (int i = 0; i < 5; i++) push_cmd(c[i], ok);
      repeat (4) @(negedge clk);
      checks++;
      if (cmd_count !== 3'd4 || cmd_ready !== 1'b0) begin
         errors++; $display("FAIL fill_full got count=%0d ready=%0d want 4/0",
                            cmd_count, cmd_ready);
      end
      checks++;
      if (en_log.size() != 1 || en_log[0] !== c[0]) begin
         errors++; $display("FAIL fill_first got n=%0d want 1", en_log.size());
      end
      cmd_valid = 1'b1;
      {cmd_addr, cmd_rw, cmd_mem_addr, cmd_data} = {7'h15, 1'b1, 5'd9, 8'h99};
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (cmd_count !== 3'd4) begin
         errors++; $display("FAIL fill_overflow got %0d want 4", cmd_count);
      end
      hold_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         get_rsp(200, ok, r);
         checks++;
         if (!ok || r !== exp_rsp(c[i][13], b[i])) begin
            errors++; $display("FAIL fill_rsp%0d got ok=%0d %0h want %0h",
                               i, ok, r, exp_rsp(c[i][13], b[i]));
         end
      end
      checks++;
      if (en_log.size() != 5) begin
         errors++; $display("FAIL fill_count got %0d want 5", en_log.size());
      end else begin
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (en_log[i] !== c[i]) begin
               errors++; $display("FAIL fill_order%0d got %0h want %0h",
                                  i, en_log[i], c[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [9:0] r;
      logic [20:0] c[6];
      beh_t b[6];
      en_log.delete(); en_cyc.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         c[i] = {7'($urandom), 1'($urandom), 5'($urandom), 8'($urandom)};
         b[i] = mk_beh(0, 1, 2, 8'($urandom), 1'($urandom));
         beh_q.push_back(b[i]);
      end
      for (int i = 0; i < 6; i++) push_cmd(c[i], ok);
      repeat (60) @(negedge clk);
      checks++;
      if (en_log.size() != 4 || cmd_count !== 3'd2 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL bp_stall got n=%0d count=%0d want 4/2",
                            en_log.size(), cmd_count);
      end
      get_rsp(10, ok, r);
      checks++;
      if (!ok || r !== exp_rsp(c[0][13], b[0])) begin
         errors++; $display("FAIL bp_rsp0 got %0h want %0h",
                            r, exp_rsp(c[0][13], b[0]));
      end
      repeat (30) @(negedge clk);
      checks++;
      if (en_log.size() != 5 || cmd_count !== 3'd1) begin
         errors++; $display("FAIL bp_resume got n=%0d count=%0d want 5/1",
                            en_log.size(), cmd_count);
      end
      for (int i = 1; i < 6; i++) begin
         get_rsp(200, ok, r);
         checks++;
         if (!ok || r !== exp_rsp(c[i][13], b[i])) begin
            errors++; $display("FAIL bp_rsp%0d got ok=%0d %0h want %0h",
                               i, ok, r, exp_rsp(c[i][13], b[i]));
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      logic [9:0] r;
      int tv;
      int lat;
      logic [20:0] ca, cb;
      en_log.delete(); en_cyc.delete();
      ca = {7'h33, 1'b0, 5'd7, 8'h00};
      cb = {7'h34, 1'b0, 5'd8, 8'h00};
      beh_q.push_back(mk_beh(1, 0, 0, 8'h00, 1'b0));
      beh_q.push_back(mk_beh(0, 2, 3, 8'h11, 1'b0));
      push_cmd(ca, ok);
      push_cmd(cb, ok);
      tv = -1;
      for (int t = 0; t < 100; t++) begin
         if (rsp_valid) begin tv = cyc; break; end
         @(negedge clk);
      end
      lat = (en_cyc.size() == 0 || tv < 0) ? -1 : tv - en_cyc[0];
      checks++;
      if (lat != START_TO + 2) begin
         errors++; $display("FAIL to_latency got %0d want %0d", lat, START_TO + 2);
      end
      checks++;
      if ({rsp_rw, rsp_data, rsp_err} !== {1'b0, 8'h00, 1'b1}) begin
         errors++; $display("FAIL to_rsp got %0h want 1",
                            {rsp_rw, rsp_data, rsp_err});
      end
      get_rsp(10, ok, r);
      get_rsp(200, ok, r);
      checks++;
      if (!ok || r !== {1'b0, 8'h11, 1'b0}) begin
         errors++; $display("FAIL to_next got ok=%0d %0h want 22", ok, r);
      end
      checks++;
      if (en_cyc.size() != 2 || en_cyc[1] - en_cyc[0] != START_TO + 3) begin
         errors++; $display("FAIL to_relaunch got n=%0d want 2 at +%0d",
                            en_cyc.size(), START_TO + 3);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      en_log.delete(); en_cyc.delete();
      rsp_ready = 1'b0;
      beh_q.push_back(mk_beh(0, 1, 2, 8'h77, 1'b0));
      push_cmd({7'h40, 1'b0, 5'd2, 8'h00}, ok);
      repeat (20) @(negedge clk);
      hold_busy = 1'b1;
      beh_q.push_back(mk_beh(2, 2, 0, 8'h66, 1'b0));
      for (int i = 0; i < 3; i++) push_cmd({7'h41, 1'b1, 5'(i), 8'(i)}, ok);
      repeat (6) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || cmd_count !== 3'd2 || en_log.size() != 2) begin
         errors++; $display("FAIL rm_setup got v=%0d count=%0d n=%0d want 1/2/2",
                            rsp_valid, cmd_count, en_log.size());
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (m_en !== 1'b0 || cmd_count !== 3'd0 ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL rm_state got en=%0d count=%0d v=%0d rdy=%0d want 0/0/0/1",
                            m_en, cmd_count, rsp_valid, cmd_ready);
      end
      hold_busy = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || en_log.size() != 2) begin
         errors++; $display("FAIL rm_aborted got v=%0d n=%0d want 0/2",
                            rsp_valid, en_log.size());
      end
      beh_q.delete();
   endtask

   task automatic test_random();
      localparam int N = 16;
      logic [20:0] c[N];
      logic [9:0] ex[N];
      logic [9:0] r;
      beh_t b;
      bit pok;
      bit got;
      en_log.delete(); en_cyc.delete(); dbl_en = 0; ovl = 0;
      for (int i = 0; i < N; i++) begin
         c[i] = {7'($urandom), 1'($urandom), 5'($urandom), 8'($urandom)};
         b = mk_beh(($urandom_range(0, 5) == 0) ? 1 : 0,
                    $urandom_range(1, 6), $urandom_range(1, 6),
                    8'($urandom), 1'($urandom));
         beh_q.push_back(b);
         ex[i] = exp_rsp(c[i][13], b);
      end
      fork
         begin
            for (int i = 0; i < N; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               push_cmd(c[i], pok);
               checks++;
               if (!pok) begin
                  errors++; $display("FAIL rnd_push%0d got 0 want 1", i);
               end
            end
         end
         begin
            for (int i = 0; i < N; i++) begin
               got = 1'b0;
               r = '0;
               for (int t = 0; t < 800 && !got; t++) begin
                  rsp_ready = 1'($urandom_range(0, 1));
                  if (rsp_valid && rsp_ready) begin
                     got = 1'b1;
                     r = {rsp_rw, rsp_data, rsp_err};
                  end
                  @(negedge clk);
               end
               checks++;
               if (!got || r !== ex[i]) begin
                  errors++; $display("FAIL rnd_rsp%0d got ok=%0d %0h want %0h",
                                     i, got, r, ex[i]);
               end
            end
            rsp_ready = 1'b0;
         end
      join
      checks++;
      if (en_log.size() != N || dbl_en != 0 || ovl != 0) begin
         errors++; $display("FAIL rnd_launches got n=%0d dbl=%0d ovl=%0d want %0d/0/0",
                            en_log.size(), dbl_en, ovl, N);
      end else begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (en_log[i] !== c[i]) begin
               errors++; $display("FAIL rnd_order%0d got %0h want %0h",
                                  i, en_log[i], c[i]);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_fill();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
- Command sequencer that sits directly upstream of i2c_master.
- Buffers host I2C register commands (slave addr, rw, mem_addr, write data) in a command FIFO and issues them one at a time.
- Each issue is a single-cycle enable pulse with stable fields; the block then tracks master busy, captures data_rd/ack_err, and queues a response per command in a response FIFO.
- Replaces hand-driven en/addr/rw/mem_addr/data_wr stimulus with a valid/ready host interface.

Parameters:
DEPTH, 4, entries in each FIFO (power of 2, >=2)
AW, 2, log2(DEPTH)
START_TO, 16, cycles to wait for m_busy after launch before declaring start timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  command FIFO not full
cmd_addr  in  7  target slave address
cmd_rw  in  1  1=write, 0=read
cmd_mem_addr  in  5  slave register address
cmd_data  in  8  write data (ignored for reads)
cmd_count  out  AW+1  commands queued, not yet launched
rsp_valid  out  1  response FIFO non-empty
rsp_ready  in  1  host pops response
rsp_rw  out  1  rw of completed command
rsp_data  out  8  read data (0x00 for writes/timeouts)
rsp_err  out  1  ack error or start timeout
m_en  out  1  enable pulse to master
m_addr  out  7  to master addr
m_rw  out  1  to master rw
m_mem_addr  out  5  to master mem_addr
m_data_wr  out  8  to master data_wr
m_data_rd  in  8  from master data_rd
m_ack_err  in  1  from master ack_err
m_busy  in  1  from master busy

Behaviour:
- Reset (sync, high):
  - Both FIFOs emptied; state IDLE; timeout counter 0.
  - m_en, m_addr, m_rw, m_mem_addr, m_data_wr, cmd_count, rsp_valid, rsp_rw, rsp_data, rsp_err all 0.
  - cmd_ready reads 1 in the first cycle after rst deasserts.
  - In-flight transaction result is discarded; cmd_valid is ignored during reset.
- Command FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready = !full; stays 0 when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle (not full): count unchanged.
  - Pointers wrap modulo DEPTH; strict FIFO order.
- Response FIFO:
  - First-word-fall-through; rsp_* show the head entry. Pop on rsp_valid&&rsp_ready.
  - Launch is blocked while the response FIFO is full, so it never overflows.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
  - IDLE: cmd FIFO non-empty and rsp FIFO not full -> LAUNCH. On that transition, pop head and load m_addr/m_rw/m_mem_addr/m_data_wr.
  - LAUNCH: m_en=1 for exactly this cycle -> WAIT_BUSY; counter cleared.
  - WAIT_BUSY: m_busy=1 -> WAIT_DONE. Otherwise counter++; at counter==START_TO-1 -> RESP with err=1, data=0x00.
  - WAIT_DONE: m_busy=0 -> RESP. On that transition, latch err=m_ack_err, data=(m_rw?0x00:m_data_rd).
  - RESP: push {m_rw, data, err} into rsp FIFO -> IDLE.
- m_en is a flop, high only in LAUNCH. m_* fields hold stable from LAUNCH until the next IDLE->LAUNCH reload.
- Latency: command accepted at edge k -> m_en high in cycle k+2 (empty FIFO, IDLE). Response visible the cycle after RESP.
- Exactly one outstanding transaction; no overlap of launches.
- cmd_count counts queued entries only; the launched command is excluded.

Test Plan:
- Write: cmd addr=1 rw=1 mem=3 data=0x33; model busy high 2 cycles after m_en for 20 cycles, ack_err=0 -> m_en single pulse at k+2 with m_addr=1, m_mem_addr=3, m_data_wr=0x33; response rw=1 data=0x00 err=0.
- Read: addr=2 rw=0 mem=1; model returns data_rd=0xBB, ack_err=0 -> rsp_data=0xBB, rsp_rw=0, err=0. Repeat with ack_err=1 -> err=1.
- Fill: busy held high, push 5 cmds (mem 0..4) -> first launched, cmd_count=4, cmd_ready=0. Release busy -> launches in order mem 1,2,3,4.
- Backpressure: rsp_ready=0, push 6 cmds -> exactly 4 responses queued, no 5th m_en until one rsp pop; then 5th launches.
- Timeout: busy never asserted -> rsp_err=1, rsp_data=0x00 START_TO+2 cycles after m_en; next queued cmd then launches.
- Reset in WAIT_DONE with 2 queued, 1 response pending -> next cycle m_en=0, cmd_count=0, rsp_valid=0, cmd_ready=1; no response for the aborted command.
